// File: rtl/axi_stream_extract_header.sv
// Strips a per-packet header of H bytes off an AXI-Stream packet and realigns the payload.
// Optional macro AXIS_EXTRACT_PKT_CNT_EN adds a 16-bit count of completed packets (pkt_cnt).
module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  input  logic                    valid_strip,
  output logic                    ready_strip,
  input  logic [DATA_BYTE_WD-1:0] keep_strip,
  output logic                    valid_hdr,
  input  logic                    ready_hdr,
  output logic [DATA_WD-1:0]      header_out,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out
`ifdef AXIS_EXTRACT_PKT_CNT_EN
  ,
  output logic [15:0]             pkt_cnt
`endif
);

  localparam int NB = DATA_BYTE_WD;
  localparam int CW = $clog2(NB + 1);
  localparam int TW = CW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FIRST = 2'd1;
  localparam logic [1:0] S_BODY  = 2'd2;
  localparam logic [1:0] S_TAIL  = 2'd3;

  function automatic logic [CW-1:0] popcnt(input logic [NB-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NB; i++) c = c + CW'(m[i]);
    return c;
  endfunction

  function automatic logic [NB-1:0] msb_mask(input logic [TW-1:0] n);
    logic [NB-1:0] ones;
    ones = '1;
    return ~(ones >> n);
  endfunction

  function automatic logic [DATA_WD-1:0] mask_bytes(input logic [DATA_WD-1:0] d,
                                                    input logic [NB-1:0] k);
    logic [DATA_WD-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
    return r;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        h_q, h_d;
  logic [NB-1:0]        ks_q, ks_d;
  logic [DATA_WD-1:0]   res_q, res_d;
  logic [CW-1:0]        rcnt_q, rcnt_d;
  logic [DATA_WD-1:0]   dout_q, dout_d;
  logic [NB-1:0]        kout_q, kout_d;
  logic                 lout_q, lout_d;
  logic                 vout_q, vout_d;
  logic [DATA_WD-1:0]   hdr_q, hdr_d;
  logic [NB-1:0]        khdr_q, khdr_d;
  logic                 vhdr_q, vhdr_d;

  logic                 free;
  logic [DATA_WD-1:0]   din_m;
  logic [CW-1:0]        r_cnt;
  logic [2*DATA_WD-1:0] cat;
  logic [TW-1:0]        t_cnt;

  assign free        = !vout_q || ready_out;
  assign ready_in    = ((state_q == S_FIRST) && !vhdr_q && free) || ((state_q == S_BODY) && free);
  // A new strip length is only taken once the previous packet's last beat has left.
  assign ready_strip = rst_n && (state_q == S_IDLE) && !vout_q;
  assign din_m       = mask_bytes(data_in, keep_in);
  assign r_cnt       = popcnt(keep_in);

  // cat holds the pending byte stream MSB-first: upper half is the next output beat.
  always_comb begin
    if (state_q == S_FIRST) begin
      cat   = {din_m, {DATA_WD{1'b0}}} << {h_q, 3'b000};
      t_cnt = (r_cnt > h_q) ? TW'(r_cnt - h_q) : '0;
    end else begin
      cat   = {res_q, {DATA_WD{1'b0}}} | ({din_m, {DATA_WD{1'b0}}} >> {rcnt_q, 3'b000});
      t_cnt = TW'(rcnt_q) + TW'(r_cnt);
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    ks_d    = ks_q;
    res_d   = res_q;
    rcnt_d  = rcnt_q;
    dout_d  = dout_q;
    kout_d  = kout_q;
    lout_d  = lout_q;
    vout_d  = vout_q && !ready_out;
    hdr_d   = hdr_q;
    khdr_d  = khdr_q;
    vhdr_d  = vhdr_q && !ready_hdr;
    case (state_q)
      S_IDLE: begin
        if (valid_strip && ready_strip) begin
          h_d     = popcnt(keep_strip);
          ks_d    = keep_strip;
          res_d   = '0;
          rcnt_d  = '0;
          state_d = S_FIRST;
        end
      end
      S_FIRST, S_BODY: begin
        if (valid_in && ready_in) begin
          if (state_q == S_FIRST) begin
            hdr_d  = din_m >> {CW'(NB) - h_q, 3'b000};
            khdr_d = ks_q;
            vhdr_d = (h_q != '0);
          end
          state_d = S_BODY;
          if (last_in && (t_cnt <= TW'(NB))) begin
            dout_d  = cat[2*DATA_WD-1:DATA_WD];
            kout_d  = msb_mask(t_cnt);
            lout_d  = 1'b1;
            vout_d  = 1'b1;
            res_d   = '0;
            rcnt_d  = '0;
            state_d = S_IDLE;
          end else if (t_cnt >= TW'(NB)) begin
            dout_d = cat[2*DATA_WD-1:DATA_WD];
            kout_d = '1;
            lout_d = 1'b0;
            vout_d = 1'b1;
            res_d  = cat[DATA_WD-1:0];
            rcnt_d = CW'(t_cnt - TW'(NB));
            if (last_in) state_d = S_TAIL;
          end else begin
            res_d  = cat[2*DATA_WD-1:DATA_WD];
            rcnt_d = CW'(t_cnt);
          end
        end
      end
      default: begin
        if (free) begin
          dout_d  = res_q;
          kout_d  = msb_mask(TW'(rcnt_q));
          lout_d  = 1'b1;
          vout_d  = 1'b1;
          res_d   = '0;
          rcnt_d  = '0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      ks_q    <= '0;
      res_q   <= '0;
      rcnt_q  <= '0;
      dout_q  <= '0;
      kout_q  <= '0;
      lout_q  <= 1'b0;
      vout_q  <= 1'b0;
      hdr_q   <= '0;
      khdr_q  <= '0;
      vhdr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      ks_q    <= ks_d;
      res_q   <= res_d;
      rcnt_q  <= rcnt_d;
      dout_q  <= dout_d;
      kout_q  <= kout_d;
      lout_q  <= lout_d;
      vout_q  <= vout_d;
      hdr_q   <= hdr_d;
      khdr_q  <= khdr_d;
      vhdr_q  <= vhdr_d;
    end
  end

  assign valid_out  = vout_q;
  assign data_out   = dout_q;
  assign keep_out   = kout_q;
  assign last_out   = lout_q;
  assign valid_hdr  = vhdr_q;
  assign header_out = hdr_q;
  assign keep_hdr   = khdr_q;

`ifdef AXIS_EXTRACT_PKT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = (vout_q && ready_out && lout_q) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Bench for axi_stream_extract_header: directed vector table, reset corner cases and
// randomized packets checked against a byte-level packet model.
module tb_axi_stream_extract_header;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        valid_strip = 1'b0;
  logic        ready_strip;
  logic [3:0]  keep_strip = '0;
  logic        valid_hdr;
  logic        ready_hdr = 1'b1;
  logic [31:0] header_out;
  logic [3:0]  keep_hdr;
  logic        valid_out;
  logic        ready_out = 1'b1;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
`ifdef AXIS_EXTRACT_PKT_CNT_EN
  logic [15:0] pkt_cnt;
`endif

  axi_stream_extract_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .valid_strip(valid_strip), .ready_strip(ready_strip), .keep_strip(keep_strip),
    .valid_hdr(valid_hdr), .ready_hdr(ready_hdr), .header_out(header_out), .keep_hdr(keep_hdr),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .keep_out(keep_out),
    .last_out(last_out)
`ifdef AXIS_EXTRACT_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t       out_q[$];
  beat_t       exp_q[$];
  logic [35:0] hdr_q[$];
  logic [35:0] exph_q[$];
  logic [7:0]  pb[$];
  logic [31:0] bd[$];
  logic [3:0]  bk[$];
  int          last_cnt = 0;
  int          rmode = 0;

  typedef struct packed {
    logic [3:0]       ks;
    logic [1:0][31:0] d;
    logic [1:0][3:0]  k;
    int               nb;
    logic [31:0]      exp_hdr;
    logic [3:0]       exp_khdr;
    int               exp_nh;
    int               exp_no;
    logic [1:0][31:0] exp_d;
    logic [1:0][3:0]  exp_k;
    logic [1:0]       exp_l;
  } vec_t;

  vec_t vt[3];

  // Transfers are observed mid-cycle, where valid/ready are stable until the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out && ready_out) begin
        out_q.push_back({data_out, keep_out, last_out});
        if (last_out) last_cnt++;
      end
      if (valid_hdr && ready_hdr) hdr_q.push_back({header_out, keep_hdr});
    end
  end

  always begin
    @(posedge clk);
    #1;
    case (rmode)
      0:       ready_out = 1'b1;
      1:       ready_out = ~ready_out;
      default: ready_out = ($urandom_range(0, 3) != 0);
    endcase
    ready_hdr = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_strip(input logic [3:0] ks);
    bit done = 0;
    valid_strip = 1'b1;
    keep_strip  = ks;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      done = ready_strip;
      @(posedge clk);
      #1;
    end
    valid_strip = 1'b0;
    if (!done) chk("strip_timeout", 36'd0, 36'd1);
  endtask

  task automatic do_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit done = 0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      done = ready_in;
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    if (!done) chk("beat_timeout", 36'd0, 36'd1);
  endtask

  task automatic send_pkt(input logic [3:0] ks, input bit gaps);
    do_strip(ks);
    for (int i = 0; i < bd.size(); i++) begin
      do_beat(bd[i], bk[i], i == bd.size() - 1);
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  task automatic wait_out(input int n_out, input int n_hdr);
    int i = 0;
    while ((out_q.size() < n_out || hdr_q.size() < n_hdr) && i < 5000) begin
      idle(1);
      i++;
    end
    if (i >= 5000) chk("output_timeout", 36'(out_q.size()), 36'(n_out));
    idle(6);
  endtask

  task automatic bytes_to_beats();
    bd.delete();
    bk.delete();
    for (int s = 0; s < pb.size(); s += 4) begin
      logic [31:0] d = '0;
      logic [3:0]  k = '0;
      for (int j = 0; j < 4; j++)
        if (s + j < pb.size()) begin
          d[31-8*j -: 8] = pb[s+j];
          k[3-j] = 1'b1;
        end
      bd.push_back(d);
      bk.push_back(k);
    end
  endtask

  // Packet-level view: first h bytes form the header, the rest is re-packed 4 per beat.
  task automatic model_pkt(input int h);
    logic [31:0] hw = '0;
    int p = pb.size() - h;
    if (h > 0) begin
      for (int i = 0; i < h; i++)
        if (i < pb.size()) hw[8*(h-1-i) +: 8] = pb[i];
      exph_q.push_back({hw, 4'((1 << h) - 1)});
    end
    if (p <= 0) exp_q.push_back({32'h0, 4'h0, 1'b1});
    else begin
      for (int s = h; s < pb.size(); s += 4) begin
        logic [31:0] d = '0;
        logic [3:0]  k = '0;
        for (int j = 0; j < 4; j++)
          if (s + j < pb.size()) begin
            d[31-8*j -: 8] = pb[s+j];
            k[3-j] = 1'b1;
          end
        exp_q.push_back({d, k, (s + 4 >= pb.size())});
      end
    end
  endtask

  task automatic compare_model(input string tag);
    wait_out(exp_q.size(), exph_q.size());
    chk({tag, "_nout"}, 36'(out_q.size()), 36'(exp_q.size()));
    chk({tag, "_nhdr"}, 36'(hdr_q.size()), 36'(exph_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      chk({tag, "_beat"}, 36'({out_q[i].d, out_q[i].k}), 36'({exp_q[i].d, exp_q[i].k}));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      chk({tag, "_last"}, 36'(out_q[i].l), 36'(exp_q[i].l));
    for (int i = 0; i < exph_q.size() && i < hdr_q.size(); i++)
      chk({tag, "_hdr"}, hdr_q[i], exph_q[i]);
    out_q.delete(); hdr_q.delete(); exp_q.delete(); exph_q.delete();
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    out_q.delete();
    hdr_q.delete();
    bd.delete();
    bk.delete();
    for (int i = 0; i < v.nb; i++) begin
      bd.push_back(v.d[i]);
      bk.push_back(v.k[i]);
    end
    send_pkt(v.ks, 1'b0);
    wait_out(v.exp_no, v.exp_nh);
    chk({tag, "_nout"}, 36'(out_q.size()), 36'(v.exp_no));
    chk({tag, "_nhdr"}, 36'(hdr_q.size()), 36'(v.exp_nh));
    for (int j = 0; j < v.exp_no && j < out_q.size(); j++) begin
      chk({tag, "_data"}, 36'(out_q[j].d), 36'(v.exp_d[j]));
      chk({tag, "_keep_last"}, 36'({out_q[j].k, out_q[j].l}), 36'({v.exp_k[j], v.exp_l[j]}));
    end
    if (v.exp_nh > 0 && hdr_q.size() > 0)
      chk({tag, "_hdr"}, hdr_q[0], {v.exp_hdr, v.exp_khdr});
    out_q.delete();
    hdr_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valids"}, 36'({valid_out, valid_hdr, ready_in, ready_strip}), 36'd0);
    chk({tag, "_data_out"}, 36'({data_out, keep_out}), 36'd0);
    chk({tag, "_last_out"}, 36'(last_out), 36'd0);
    chk({tag, "_header"}, {header_out, keep_hdr}, 36'd0);
  endtask

  initial begin
    int base;
    vt[0] = '{ks: 4'b0011, d: {32'h33445566, 32'hAABB1122}, k: {4'hF, 4'hF}, nb: 2,
              exp_hdr: 32'h0000AABB, exp_khdr: 4'b0011, exp_nh: 1, exp_no: 2,
              exp_d: {32'h55660000, 32'h11223344}, exp_k: {4'hC, 4'hF}, exp_l: 2'b10};
    vt[1] = '{ks: 4'b0000, d: {32'h05060000, 32'h01020304}, k: {4'hC, 4'hF}, nb: 2,
              exp_hdr: 32'h0, exp_khdr: 4'h0, exp_nh: 0, exp_no: 2,
              exp_d: {32'h05060000, 32'h01020304}, exp_k: {4'hC, 4'hF}, exp_l: 2'b10};
    vt[2] = '{ks: 4'b1111, d: {32'h0, 32'hDEADBEEF}, k: {4'h0, 4'hF}, nb: 1,
              exp_hdr: 32'hDEADBEEF, exp_khdr: 4'hF, exp_nh: 1, exp_no: 1,
              exp_d: {32'h0, 32'h0}, exp_k: {4'h0, 4'h0}, exp_l: 2'b01};

    #3 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("ready_strip_idle", 36'(ready_strip), 36'd1);
    chk("ready_in_idle", 36'(ready_in), 36'd0);

    for (int i = 0; i < 3; i++) apply_vec(vt[i], $sformatf("vec%0d", i));

    // One-byte header, 8 full beats, output backpressure alternating every cycle.
    rmode = 1;
    pb.delete();
    for (int i = 0; i < 32; i++) pb.push_back(8'(i + 8'h40));
    model_pkt(1);
    bytes_to_beats();
    send_pkt(4'b0001, 1'b0);
    compare_model("toggle");
    rmode = 0;

    // Asynchronous reset in the middle of a packet body.
    pb.delete();
    for (int i = 0; i < 24; i++) pb.push_back(8'(i + 1));
    bytes_to_beats();
    do_strip(4'b0011);
    for (int i = 0; i < 3; i++) do_beat(bd[i], bk[i], 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    idle(2);
    rst_n = 1'b1;
    out_q.delete();
    hdr_q.delete();
    idle(2);
    base = last_cnt;
    for (int i = 0; i < 3; i++) apply_vec(vt[i], $sformatf("post%0d", i));
`ifdef AXIS_EXTRACT_PKT_CNT_EN
    chk("pkt_cnt_three", 36'(pkt_cnt), 36'd3);
`endif

    rmode = 2;
    for (int p = 0; p < 40; p++) begin
      int h = $urandom_range(0, 4);
      int len = $urandom_range(1, 14);
      pb.delete();
      for (int i = 0; i < len; i++) pb.push_back(8'($urandom));
      model_pkt(h);
      bytes_to_beats();
      send_pkt(4'((1 << h) - 1), 1'b1);
    end
    compare_model("rand");
    rmode = 0;
    idle(4);
`ifdef AXIS_EXTRACT_PKT_CNT_EN
    chk("pkt_cnt_total", 36'(pkt_cnt), 36'(16'(last_cnt - base)));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
